// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
// Holds the exception vector, exception codes and the stage-header bundle.
package pipe_stage_reg_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    typedef logic [4:0] exccode_t;

    localparam exccode_t EXC_INT  = 5'd0;
    localparam exccode_t EXC_ADEL = 5'd4;
    localparam exccode_t EXC_ADES = 5'd5;
    localparam exccode_t EXC_RI   = 5'd10;
    localparam exccode_t EXC_OV   = 5'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        exccode_t    exccode;
        logic        delayed;
        logic        valid;
    } stage_hdr_t;

    // Empty header, optionally keeping the pc/exception info needed for EPC/BD.
    function automatic stage_hdr_t hdr_bubble(input logic [31:0] pc,
                                              input exccode_t    exccode,
                                              input logic        delayed);
        stage_hdr_t h;
        h         = '0;
        h.pc      = pc;
        h.exccode = exccode;
        h.delayed = delayed;
        return h;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline
// bubble/hold performance monitoring.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_reg;

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value_reg <= '0;
        end else if (inc && (value_reg != {CNT_W{1'b1}})) begin
            value_reg <= value_reg + 1'b1;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D/E, E/M, M/W) carrying pc, instr, exccode,
// delay-slot flag, valid bit and a configurable payload, with perf counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          PAYLOAD_W     = 96,
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter bit          STALL_KEEP_PC = 1'b1,
    parameter int          CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 enable,
    input  logic                 cnt_clr,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [4:0]           in_exccode,
    input  logic                 in_delayed,
    input  logic                 in_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [4:0]           out_exccode,
    output logic                 out_delayed,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     hold_cnt
);

    stage_hdr_t           hdr_reg, hdr_next;
    logic [PAYLOAD_W-1:0] payload_reg, payload_next;
    logic                 bubble_cycle;
    logic                 hold_cycle;

    // Fixed priority: req > flush > stall > enable > hold (reset handled in the flop).
    always_comb begin
        hdr_next     = hdr_reg;
        payload_next = payload_reg;
        bubble_cycle = 1'b0;
        hold_cycle   = 1'b0;
        if (req) begin
            hdr_next     = hdr_bubble(EXC_VECTOR, EXC_INT, 1'b0);
            payload_next = '0;
            bubble_cycle = 1'b1;
        end else if (flush) begin
            hdr_next     = '0;
            payload_next = '0;
            bubble_cycle = 1'b1;
        end else if (stall) begin
            if (STALL_KEEP_PC) begin
                hdr_next = hdr_bubble(in_pc, in_exccode, in_delayed);
            end else begin
                hdr_next = '0;
            end
            payload_next = '0;
            bubble_cycle = 1'b1;
        end else if (enable) begin
            hdr_next.pc      = in_pc;
            hdr_next.instr   = in_instr;
            hdr_next.exccode = in_exccode;
            hdr_next.delayed = in_delayed;
            hdr_next.valid   = in_valid;
            payload_next     = in_payload;
        end else begin
            hold_cycle = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_reg     <= '0;
            payload_reg <= '0;
        end else begin
            hdr_reg     <= hdr_next;
            payload_reg <= payload_next;
        end
    end

    assign out_pc      = hdr_reg.pc;
    assign out_instr   = hdr_reg.instr;
    assign out_exccode = hdr_reg.exccode;
    assign out_delayed = hdr_reg.delayed;
    assign out_valid   = hdr_reg.valid;
    assign out_payload = payload_reg;

    // Counter 0 tracks bubbles, counter 1 tracks hold cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_value [2];

    assign cnt_inc = {hold_cycle, bubble_cycle};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .value (cnt_value[gi])
            );
        end
    endgenerate

    assign bubble_cnt = cnt_value[0];
    assign hold_cnt   = cnt_value[1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (default parameters, and
// STALL_KEEP_PC=0 / CNT_W=2 / PAYLOAD_W=8) driven by the same directed vectors.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, flush, stall, enable, cnt_clr;
    logic [31:0] in_pc, in_instr;
    logic [95:0] in_payload;
    logic [4:0]  in_exccode;
    logic        in_delayed, in_valid;

    logic [31:0] a_pc, a_instr;
    logic [95:0] a_payload;
    logic [4:0]  a_exc;
    logic        a_del, a_val;
    logic [15:0] a_bub, a_hold;

    logic [31:0] b_pc, b_instr;
    logic [7:0]  b_payload;
    logic [4:0]  b_exc;
    logic        b_del, b_val;
    logic [1:0]  b_bub, b_hold;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .enable(enable), .cnt_clr(cnt_clr), .in_pc(in_pc), .in_instr(in_instr),
        .in_payload(in_payload), .in_exccode(in_exccode), .in_delayed(in_delayed),
        .in_valid(in_valid), .out_pc(a_pc), .out_instr(a_instr),
        .out_payload(a_payload), .out_exccode(a_exc), .out_delayed(a_del),
        .out_valid(a_val), .bubble_cnt(a_bub), .hold_cnt(a_hold)
    );

    pipe_stage_reg #(
        .PAYLOAD_W(8), .STALL_KEEP_PC(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .enable(enable), .cnt_clr(cnt_clr), .in_pc(in_pc), .in_instr(in_instr),
        .in_payload(in_payload[7:0]), .in_exccode(in_exccode), .in_delayed(in_delayed),
        .in_valid(in_valid), .out_pc(b_pc), .out_instr(b_instr),
        .out_payload(b_payload), .out_exccode(b_exc), .out_delayed(b_del),
        .out_valid(b_val), .bubble_cnt(b_bub), .hold_cnt(b_hold)
    );

    typedef struct packed {
        logic [7:0]  step;
        logic [31:0] pc, instr;
        logic [95:0] payload;
        logic [4:0]  exc;
        logic        del, val;
        logic [15:0] bub, hold;
        logic [31:0] b_pc, b_instr;
        logic [7:0]  b_payload;
        logic [4:0]  b_exc;
        logic        b_del, b_val;
        logic [1:0]  b_bub, b_hold;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input int step,
                       input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    endtask

    // Monitor: every clock the DUT presents a new registered state; compare it
    // against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("a_pc",      x.step, 96'(a_pc),      96'(x.pc));
                chk("a_instr",   x.step, 96'(a_instr),   96'(x.instr));
                chk("a_payload", x.step, a_payload,      x.payload);
                chk("a_exccode", x.step, 96'(a_exc),     96'(x.exc));
                chk("a_delayed", x.step, 96'(a_del),     96'(x.del));
                chk("a_valid",   x.step, 96'(a_val),     96'(x.val));
                chk("a_bubble",  x.step, 96'(a_bub),     96'(x.bub));
                chk("a_hold",    x.step, 96'(a_hold),    96'(x.hold));
                chk("b_pc",      x.step, 96'(b_pc),      96'(x.b_pc));
                chk("b_instr",   x.step, 96'(b_instr),   96'(x.b_instr));
                chk("b_payload", x.step, 96'(b_payload), 96'(x.b_payload));
                chk("b_exccode", x.step, 96'(b_exc),     96'(x.b_exc));
                chk("b_delayed", x.step, 96'(b_del),     96'(x.b_del));
                chk("b_valid",   x.step, 96'(b_val),     96'(x.b_val));
                chk("b_bubble",  x.step, 96'(b_bub),     96'(x.b_bub));
                chk("b_hold",    x.step, 96'(b_hold),    96'(x.b_hold));
                $display("step %0d: a_pc=%h a_valid=%b a_bub=%0d a_hold=%0d b_pc=%h b_bub=%0d b_hold=%0d",
                         x.step, a_pc, a_val, a_bub, a_hold, b_pc, b_bub, b_hold);
            end
        end
    end

    // Push the expectation for the edge that captures the current inputs.
    task automatic issue();
        sb_q.push_back(e);
        e.step = e.step + 8'd1;
        @(negedge clk);
    endtask

    task automatic ctrl(input logic r, input logic q, input logic f,
                        input logic s, input logic en, input logic clr);
        reset = r; req = q; flush = f; stall = s; enable = en; cnt_clr = clr;
    endtask

    task automatic data(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [95:0] pl, input logic [4:0] exc,
                        input logic del, input logic val);
        in_pc = pc; in_instr = instr; in_payload = pl;
        in_exccode = exc; in_delayed = del; in_valid = val;
    endtask

    task automatic zero_data_exp();
        e.pc = '0; e.instr = '0; e.payload = '0; e.exc = '0; e.del = 1'b0; e.val = 1'b0;
        e.b_pc = '0; e.b_instr = '0; e.b_payload = '0; e.b_exc = '0; e.b_del = 1'b0; e.b_val = 1'b0;
    endtask

    initial begin
        e = '0;
        // Step 0: plain reset.
        ctrl(1, 0, 0, 0, 0, 0);
        data(32'h0, 32'h0, 96'h0, 5'd0, 1'b0, 1'b0);
        issue();

        // Step 1: reset alongside enable must still zero everything.
        ctrl(1, 0, 0, 0, 1, 0);
        data(32'h0000_3010, 32'h2401_0005, 96'h77, 5'd0, 1'b0, 1'b1);
        issue();

        // Step 2: load.
        ctrl(0, 0, 0, 0, 1, 0);
        data(32'h0000_3000, 32'h2401_0005, 96'h0123_4567_89ab_cdef_0011_2233, EXC_INT, 1'b0, 1'b1);
        e.pc = 32'h0000_3000; e.instr = 32'h2401_0005;
        e.payload = 96'h0123_4567_89ab_cdef_0011_2233; e.val = 1'b1;
        e.b_pc = 32'h0000_3000; e.b_instr = 32'h2401_0005; e.b_payload = 8'h33; e.b_val = 1'b1;
        issue();

        // Step 3: stall bubble; instance A keeps pc/exccode/delayed, B zeroes.
        ctrl(0, 0, 0, 1, 0, 0);
        data(32'h0000_3004, 32'h1234_5678, {96{1'b1}}, EXC_ADEL, 1'b1, 1'b1);
        zero_data_exp();
        e.pc = 32'h0000_3004; e.exc = EXC_ADEL; e.del = 1'b1;
        e.bub = 16'd1; e.b_bub = 2'd1;
        issue();

        // Step 4: req + stall + enable: req wins.
        ctrl(0, 1, 0, 1, 1, 0);
        data(32'h0000_3008, 32'h1234_5678, 96'h55, EXC_ADES, 1'b1, 1'b1);
        zero_data_exp();
        e.pc = 32'h0000_4180; e.b_pc = 32'h0000_4180;
        e.bub = 16'd2; e.b_bub = 2'd2;
        issue();

        // Step 5: load 0x3008.
        ctrl(0, 0, 0, 0, 1, 0);
        data(32'h0000_3008, 32'h8c22_0000, 96'h5a, EXC_INT, 1'b0, 1'b1);
        e.pc = 32'h0000_3008; e.instr = 32'h8c22_0000; e.payload = 96'h5a; e.val = 1'b1;
        e.b_pc = 32'h0000_3008; e.b_instr = 32'h8c22_0000; e.b_payload = 8'h5a; e.b_val = 1'b1;
        issue();

        // Steps 6-8: three hold cycles with changing inputs.
        ctrl(0, 0, 0, 0, 0, 0);
        data(32'hdead_beef, 32'hffff_ffff, {96{1'b1}}, EXC_OV, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            e.hold = 16'(i); e.b_hold = 2'(i);
            issue();
        end

        // Step 9: clear on a hold cycle beats the increment.
        ctrl(0, 0, 0, 0, 0, 1);
        e.hold = 16'd0; e.bub = 16'd0; e.b_hold = 2'd0; e.b_bub = 2'd0;
        issue();

        // Step 10: counting resumes.
        ctrl(0, 0, 0, 0, 0, 0);
        e.hold = 16'd1; e.b_hold = 2'd1;
        issue();

        // Steps 11-15: five flushes; the 2-bit counter saturates at 3.
        ctrl(0, 0, 1, 0, 1, 0);
        zero_data_exp();
        for (int i = 1; i <= 5; i++) begin
            e.bub = 16'(i);
            e.b_bub = (i > 3) ? 2'd3 : 2'(i);
            issue();
        end

        // Step 16: flush + clear: counters end at zero.
        ctrl(0, 0, 1, 0, 0, 1);
        e.bub = 16'd0; e.hold = 16'd0; e.b_bub = 2'd0; e.b_hold = 2'd0;
        issue();

        // Step 17: load an invalid slot with exccode/delayed set.
        ctrl(0, 0, 0, 0, 1, 0);
        data(32'h0000_3014, 32'h0000_000c, 96'h1, EXC_OV, 1'b1, 1'b0);
        e.pc = 32'h0000_3014; e.instr = 32'h0000_000c; e.payload = 96'h1;
        e.exc = EXC_OV; e.del = 1'b1; e.val = 1'b0;
        e.b_pc = 32'h0000_3014; e.b_instr = 32'h0000_000c; e.b_payload = 8'h01;
        e.b_exc = EXC_OV; e.b_del = 1'b1; e.b_val = 1'b0;
        issue();

        // Step 18: stall.
        ctrl(0, 0, 0, 1, 0, 0);
        data(32'h0000_3020, 32'h0000_0007, 96'h9, EXC_RI, 1'b0, 1'b1);
        zero_data_exp();
        e.pc = 32'h0000_3020; e.exc = EXC_RI;
        e.bub = 16'd1; e.b_bub = 2'd1;
        issue();

        // Step 19: reset mid-stall.
        ctrl(1, 0, 0, 1, 0, 0);
        zero_data_exp();
        e.bub = 16'd0; e.b_bub = 2'd0;
        issue();

        // Step 20: hold after reset, no residual state.
        ctrl(0, 0, 0, 0, 0, 0);
        data(32'h0, 32'h0, 96'h0, 5'd0, 1'b0, 1'b0);
        e.hold = 16'd1; e.b_hold = 2'd1;
        issue();

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
